// File: rtl/regbank_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : regbank_sequencer
// Brief   : Sequences read-A / read-B / execute / write-back ALU commands
//           over a shared, arbitrated register-bank read bus.
// Revision: 1.0
// ============================================================================
module regbank_sequencer #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_imm,
  input  logic [IDX_W-1:0]  cmd_src_a,
  input  logic [IDX_W-1:0]  cmd_src_b,
  input  logic [IDX_W-1:0]  cmd_dst,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [IDX_W-1:0]  rb_out_index,
  output logic              rb_out_enable,
  input  logic [DATA_W-1:0] rb_bus,
  output logic [IDX_W-1:0]  rb_en_in,
  output logic [DATA_W-1:0] rb_wr_data,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  src_a_q;
  logic [IDX_W-1:0]  src_b_q;
  logic [IDX_W-1:0]  dst_q;
  logic [DATA_W-1:0] result_q;
  logic              same_src;

  assign same_src = (src_a_q == src_b_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control outputs decode from the registered state only (plus the grant
  // for the tristate enable), so they settle right after each clock edge.
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    busy          = 1'b1;
    bus_req       = 1'b0;
    rb_out_index  = src_a_q;
    rb_out_enable = 1'b0;
    rb_en_in      = '0;
    rb_wr_data    = '0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_nxt = cmd_imm ? S_WRITE : S_READ_A;
        end
      end
      S_READ_A: begin
        bus_req       = 1'b1;
        rb_out_index  = src_a_q;
        rb_out_enable = bus_gnt;
        if (bus_gnt) begin
          state_nxt = same_src ? S_EXEC : S_READ_B;
        end
      end
      S_READ_B: begin
        bus_req       = 1'b1;
        rb_out_index  = src_b_q;
        rb_out_enable = bus_gnt;
        if (bus_gnt) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        rb_en_in   = dst_q;
        rb_wr_data = result_q;
        done       = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      result_q <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_op  <= cmd_op;
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
            dst_q   <= cmd_dst;
            if (cmd_imm) begin
              result_q <= cmd_data;
            end
          end
        end
        S_READ_A: begin
          if (bus_gnt) begin
            alu_a <= rb_bus;
            // Equal sources: one bus read feeds both operands.
            if (same_src) begin
              alu_b <= rb_bus;
            end
          end
        end
        S_READ_B: begin
          if (bus_gnt) begin
            alu_b <= rb_bus;
          end
        end
        S_EXEC: begin
          result_q <= alu_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regbank_sequencer.sv
`default_nettype none
// Testbench for regbank_sequencer: directed vector table, hand-written
// reset / busy sequences and randomized commands against a register-bank model.
module tb_regbank_sequencer;

  logic       clk = 1'b0;
  logic       RESET;
  logic       cmd_valid, cmd_ready, cmd_imm;
  logic [2:0] cmd_op, cmd_src_a, cmd_src_b, cmd_dst;
  logic [7:0] cmd_data;
  logic       bus_req, bus_gnt;
  logic [2:0] rb_out_index, rb_en_in, alu_op;
  logic       rb_out_enable;
  logic [7:0] rb_bus, rb_wr_data, alu_a, alu_b, alu_result;
  logic       busy, done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] bank [8];   // physical bank driven by the DUT
  logic [7:0] mdl  [8];   // expected architectural contents

  always #5 clk = ~clk;

  regbank_sequencer #(.DATA_W(8), .IDX_W(3)) dut (
    .CLK(clk), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_imm(cmd_imm), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
    .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .rb_out_index(rb_out_index), .rb_out_enable(rb_out_enable), .rb_bus(rb_bus),
    .rb_en_in(rb_en_in), .rb_wr_data(rb_wr_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .busy(busy), .done(done)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a;
      3'd6: return b;
      default: return ~a;
    endcase
  endfunction

  // Undriven bus reads as a junk value so a capture without grant is visible.
  assign rb_bus     = rb_out_enable ? ((rb_out_index == 3'd0) ? 8'h00 : bank[rb_out_index]) : 8'hEE;
  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (rb_en_in != 3'd0) bank[rb_en_in] <= rb_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Latency from accept edge to bank-write edge, from the grant pattern.
  function automatic int lat_of(input logic imm, input logic same, input logic [31:0] g);
    int need, cnt;
    if (imm) return 1;
    need = same ? 1 : 2;
    cnt  = 0;
    for (int i = 0; i < 32; i++) begin
      if (g[i]) begin
        cnt++;
        if (cnt == need) return i + 1 + 2;
      end
    end
    return -1;
  endfunction

  // Called between edges; returns one cycle after the write edge.
  task automatic run_cmd(input string nm, input logic imm, input logic [2:0] op,
                         input logic [2:0] a, input logic [2:0] b, input logic [2:0] dst,
                         input logic [7:0] data, input logic [31:0] gnt,
                         input logic [7:0] er, input logic [7:0] ea, input logic [7:0] eb,
                         input int elat);
    int  w;
    bit  seen;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({nm, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_imm = imm; cmd_op = op;
    cmd_src_a = a; cmd_src_b = b; cmd_dst = dst; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus_gnt = (k < 32) ? gnt[k] : 1'b1;
      @(negedge clk);
      if (!bus_gnt && rb_out_enable) chk({nm, "_oe_without_gnt"}, 32'd1, 32'd0);
      if (done) begin
        seen = 1'b1;
        chk({nm, "_latency"}, k + 1, elat);
        chk({nm, "_en_in"}, {29'd0, rb_en_in}, {29'd0, dst});
        chk({nm, "_wr_data"}, {24'd0, rb_wr_data}, {24'd0, er});
        chk({nm, "_no_req_in_write"}, {30'd0, bus_req, rb_out_enable}, 32'd0);
        if (!imm) begin
          chk({nm, "_alu_a"}, {24'd0, alu_a}, {24'd0, ea});
          chk({nm, "_alu_b"}, {24'd0, alu_b}, {24'd0, eb});
        end
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen) chk({nm, "_write_seen"}, 32'd0, 32'd1);
    if (dst != 3'd0) mdl[dst] = er;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({nm, "_idle_after"}, {30'd0, cmd_ready, busy}, 32'd2);
    if (dst != 3'd0) chk({nm, "_bank"}, {24'd0, bank[dst]}, {24'd0, er});
    @(posedge clk); #1;
  endtask

  typedef struct {
    string      nm;
    logic       imm;
    logic [2:0] op, a, b, dst;
    logic [7:0] data;
    logic [31:0] gnt;
    logic [7:0] er, ea, eb;
    int         lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"imm_r3",     1'b1, 3'd0, 3'd0, 3'd0, 3'd3, 8'h5A, 32'hFFFFFFFF, 8'h5A, 8'h00, 8'h00, 1};
    vecs[1]  = '{"imm_r0",     1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 8'hFF, 32'hFFFFFFFF, 8'hFF, 8'h00, 8'h00, 1};
    vecs[2]  = '{"imm_r1",     1'b1, 3'd0, 3'd0, 3'd0, 3'd1, 8'h12, 32'hFFFFFFFF, 8'h12, 8'h00, 8'h00, 1};
    vecs[3]  = '{"imm_r2",     1'b1, 3'd0, 3'd0, 3'd0, 3'd2, 8'h34, 32'hFFFFFFFF, 8'h34, 8'h00, 8'h00, 1};
    vecs[4]  = '{"imm_r5",     1'b1, 3'd0, 3'd0, 3'd0, 3'd5, 8'h07, 32'hFFFFFFFF, 8'h07, 8'h00, 8'h00, 1};
    vecs[5]  = '{"add_1_2",    1'b0, 3'd0, 3'd1, 3'd2, 3'd4, 8'h00, 32'hFFFFFFFF, 8'h46, 8'h12, 8'h34, 4};
    vecs[6]  = '{"contention", 1'b0, 3'd0, 3'd1, 3'd2, 3'd4, 8'h00, 32'hFFFFFFC8, 8'h46, 8'h12, 8'h34, 9};
    vecs[7]  = '{"bypass_5",   1'b0, 3'd0, 3'd5, 3'd5, 3'd6, 8'h00, 32'hFFFFFFFF, 8'h0E, 8'h07, 8'h07, 3};
    vecs[8]  = '{"xor_raw",    1'b0, 3'd4, 3'd4, 3'd3, 3'd7, 8'h00, 32'hFFFFFFFF, 8'h1C, 8'h46, 8'h5A, 4};
    vecs[9]  = '{"or_src0",    1'b0, 3'd3, 3'd0, 3'd1, 3'd2, 8'h00, 32'hFFFFFFFF, 8'h12, 8'h00, 8'h12, 4};
    vecs[10] = '{"sub_dst0",   1'b0, 3'd1, 3'd2, 3'd7, 3'd0, 8'h00, 32'hFFFFFFFA, 8'hF6, 8'h12, 8'h1C, 6};

    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    RESET = 1'b1; cmd_valid = 1'b0; cmd_imm = 1'b0; cmd_op = 3'd0;
    cmd_src_a = 3'd0; cmd_src_b = 3'd0; cmd_dst = 3'd0; cmd_data = 8'h00; bus_gnt = 1'b1;

    // Reset state (grant high without request must not matter)
    @(negedge clk); @(negedge clk);
    chk("rst_ctrl", {27'd0, bus_req, rb_out_enable, done, busy, 1'b0}, 32'd0);
    chk("rst_en_in", {29'd0, rb_en_in}, 32'd0);
    chk("rst_wr_data", {24'd0, rb_wr_data}, 32'd0);
    chk("rst_alu", {5'd0, alu_op, alu_a, alu_b, 8'd0}, 32'd0);
    RESET = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_ready", {30'd0, cmd_ready, busy}, 32'd2);
    bus_gnt = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_cmd(vecs[i].nm, vecs[i].imm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst,
              vecs[i].data, vecs[i].gnt, vecs[i].er, vecs[i].ea, vecs[i].eb, vecs[i].lat);
    end

    // cmd_valid held while busy: the second command waits and is taken once.
    begin
      int nd;
      bit drop;
      logic [7:0] exp_sub;
      exp_sub = mdl[1] - mdl[3];
      nd = 0;
      cmd_valid = 1'b1; cmd_imm = 1'b0; cmd_op = 3'd1;
      cmd_src_a = 3'd1; cmd_src_b = 3'd3; cmd_dst = 3'd4; bus_gnt = 1'b1;
      @(posedge clk); #1;
      cmd_imm = 1'b1; cmd_dst = 3'd6; cmd_data = 8'h77;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (k == 1) chk("hold_not_ready", {31'd0, cmd_ready}, 32'd0);
        if (done) begin
          nd++;
          if (nd == 1) begin
            chk("hold_first_cycle", k, 3);
            chk("hold_first_data", {21'd0, rb_en_in, rb_wr_data}, {21'd0, 3'd4, exp_sub});
          end else begin
            chk("hold_second_cycle", k, 5);
            chk("hold_second_data", {21'd0, rb_en_in, rb_wr_data}, {21'd0, 3'd6, 8'h77});
          end
        end
        drop = cmd_ready && cmd_valid;
        @(posedge clk); #1;
        if (drop) cmd_valid = 1'b0;
      end
      chk("hold_done_count", nd, 2);
      chk("hold_bank6", {24'd0, bank[6]}, 32'h77);
      mdl[4] = exp_sub;
      mdl[6] = 8'h77;
      bus_gnt = 1'b0;
    end

    // Reset during EXEC: no write back, everything back to idle.
    cmd_valid = 1'b1; cmd_imm = 1'b0; cmd_op = 3'd0;
    cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd5; bus_gnt = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("exec_busy", {30'd0, busy, done}, 32'd2);
    #2 RESET = 1'b1;
    #1;
    chk("exec_rst_outputs", {27'd0, rb_out_enable, bus_req, done, busy, 1'b0}, 32'd0);
    chk("exec_rst_en_in", {29'd0, rb_en_in}, 32'd0);
    chk("exec_rst_alu_a", {24'd0, alu_a}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); RESET = 1'b0;
    chk("exec_rst_no_write", {24'd0, bank[5]}, {24'd0, mdl[5]});
    chk("exec_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset in READ_A: the tristate enable must drop with RESET.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_imm = 1'b0; cmd_src_a = 3'd3; cmd_src_b = 3'd1; cmd_dst = 3'd7;
    @(posedge clk); #1; cmd_valid = 1'b0;
    #2 chk("reada_oe_on", {30'd0, rb_out_enable, bus_req}, 32'd3);
    RESET = 1'b1;
    #1 chk("reada_oe_drop", {30'd0, rb_out_enable, bus_req}, 32'd0);
    @(negedge clk); RESET = 1'b0; bus_gnt = 1'b0;
    @(posedge clk); #1;

    // Randomized commands against the bank model
    for (int i = 1; i < 8; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      run_cmd("rnd_preload", 1'b1, 3'd0, 3'd0, 3'd0, 3'(i), d, 32'hFFFFFFFF, d, 8'h00, 8'h00, 1);
    end
    for (int n = 0; n < 40; n++) begin
      logic       imm;
      logic [2:0] op, a, b, dst;
      logic [7:0] data, va, vb, er;
      logic [31:0] g;
      imm  = ($urandom_range(0, 3) == 0);
      op   = 3'($urandom);
      a    = 3'($urandom);
      b    = ($urandom_range(0, 3) == 0) ? a : 3'($urandom);
      dst  = 3'($urandom);
      data = 8'($urandom);
      g    = $urandom | $urandom;
      g[31:28] = 4'hF;
      va   = (a == 3'd0) ? 8'h00 : mdl[a];
      vb   = (b == 3'd0) ? 8'h00 : mdl[b];
      er   = imm ? data : alu_f(op, va, vb);
      run_cmd("rnd", imm, op, a, b, dst, data, g, er, va, vb, lat_of(imm, a == b, g));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regbank_sequencer.md
# regbank_sequencer

Multi-cycle controller that executes register-to-register ALU commands on the 8-entry register bank. The bank has a single tristate read port and one decoded write port, so the block:
- reads operand A, then operand B, over the shared bus;
- presents both operands to an external ALU and captures the result;
- writes the result back to the bank.

It requests the shared bus through a req/gnt handshake, so other bus drivers can coexist. It sits between the instruction decode front end and the register bank / ALU pair.

## Interface
- DATA_W, 8, datapath width (bank entry width)
- IDX_W, 3, register index width (8 entries; index 0 is the hard-wired zero register)
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  3  ALU operation code, passed through unchanged
- cmd_imm  in  1  1 = immediate load (write cmd_data to dst, no reads)
- cmd_src_a / cmd_src_b / cmd_dst  in  IDX_W  operand A, operand B and destination indices
- cmd_data  in  DATA_W  immediate value
- bus_req  out  1  request for the shared read bus
- bus_gnt  in  1  bus granted this cycle
- rb_out_index  out  IDX_W  bank read select
- rb_out_enable  out  1  bank tristate drive enable
- rb_bus  in  DATA_W  shared bus value
- rb_en_in  out  IDX_W  bank write select (0 = no write)
- rb_wr_data  out  DATA_W  bank write data
- alu_op  out  3  latched cmd_op
- alu_a / alu_b  out  DATA_W  latched operands
- alu_result  in  DATA_W  combinational ALU result
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse in the WRITE cycle

## Operation
- **States:** IDLE, READ_A, READ_B, EXEC, WRITE.
- **IDLE:** cmd_ready=1. On cmd_valid&cmd_ready at an edge, latch op, imm, src_a, src_b, dst and data.
  - imm=1: result_q<=cmd_data, go to WRITE.
  - Otherwise go to READ_A.
- **READ_A:** bus_req=1, rb_out_index=src_a_q, rb_out_enable=bus_gnt.
  - Edge with bus_gnt=1: alu_a<=rb_bus. Then go to READ_B, or to EXEC with alu_b<=rb_bus when src_a_q==src_b_q (single-read bypass).
  - bus_gnt=0: stay in READ_A, no capture.
- **READ_B:** same as READ_A with src_b_q. On grant, alu_b<=rb_bus, go to EXEC.
- **EXEC:** alu_op/alu_a/alu_b stable. Edge: result_q<=alu_result, go to WRITE.
- **WRITE:** rb_en_in=dst_q, rb_wr_data=result_q, done=1. Edge: go to IDLE.
  - dst_q=0 drives rb_en_in=0; the write is discarded by the bank, done still pulses.
- **Outside the active phase:** rb_out_enable=0 and bus_req=0 outside READ_A/READ_B. rb_en_in=0 outside WRITE.
- **Operand sources:** register 0 as a source reads 0 through the bank; no special case is needed.
- **cmd_valid handling:** ignored while busy. No queuing; the front end holds cmd_valid until accepted.
- **alu_op/alu_a/alu_b:** hold their last values in IDLE.
- **Widths:** no arithmetic in the block. All data paths are DATA_W, indices are IDX_W, passthrough only.

## Timing
- **Reset (async):** state=IDLE. alu_a=alu_b=result_q=0, alu_op=0. Latched indices=0. bus_req=0, rb_out_enable=0, rb_en_in=0, rb_wr_data=0, done=0, busy=0.
  - cmd_ready=1 after RESET deasserts; no command is accepted while RESET is high.
- **Reset mid-operation:** immediate return to IDLE. No write is issued. rb_out_enable drops in the same cycle RESET rises.
- **Control outputs:** rb_out_enable, rb_en_in, bus_req, done and cmd_ready are combinational from state (plus bus_gnt for rb_out_enable). They must be glitch-free relative to the CLK edge.
- **Latency from accept edge to bank-write edge (gnt held high):**
  - Register/register, distinct sources: 4 cycles.
  - Equal sources: 3 cycles.
  - Immediate: 1 cycle.
  - Each cycle of gnt low adds 1 cycle.
- **Throughput:** cmd_ready returns 1 in the cycle after WRITE. Back-to-back commands therefore take 5 (reg) or 2 (imm) cycles each.
- **Write-then-read ordering:** a write in WRITE is visible to a READ of the same index in the next command, because the bank registers update at the WRITE edge.
- **Grant without request:** bus_gnt=1 while bus_req=0 has no effect.

## Test plan
- **Reset:** assert RESET mid-cycle -> all outputs 0, cmd_ready=1 after release, busy=0.
- **Immediate load:** cmd_imm=1, dst=3, data=8'h5A -> rb_en_in=3, rb_wr_data=8'h5A one cycle after accept, done pulse. Immediate dst=0 -> rb_en_in=0, done still pulses.
- **Register op:** preload r1=8'h12, r2=8'h34. Send src_a=1, src_b=2, dst=4, op=ADD, bus_gnt=1 -> alu_a=8'h12, alu_b=8'h34. r4=8'h46 at the 4th edge after accept; done high exactly 1 cycle.
- **Bus contention:** same op with bus_gnt low for 3 cycles in READ_A and 2 in READ_B -> rb_out_enable stays 0 while gnt=0, operands still correct, write at edge 4+5=9.
- **Bypass:** src_a=src_b=5 (r5=8'h07) -> READ_B skipped, alu_a=alu_b=8'h07, write at the 3rd edge.
- **Mid-op reset and busy handling:** RESET asserted in EXEC -> no write, rb_en_in=0, state IDLE. Separately, cmd_valid held during busy -> command ignored until IDLE, then accepted once.
